// File: rtl/cpu_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : pkg_cpu
//  Description : Shared types and helpers for cpu_mem_responder: transfer
//                size encoding, responder state encoding and the function
//                mapping a request to its byte count.
//  Revision    : 1.0 - initial release
// ============================================================================
package pkg_cpu;

  // CPU transfer size; ReqDataSz48 is the 6-byte instruction fetch.
  typedef enum logic [1:0] {
    ReqDataSz8  = 2'd0,
    ReqDataSz16 = 2'd1,
    ReqDataSz32 = 2'd2,
    ReqDataSz48 = 2'd3
  } req_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    LAST = 2'd2,
    DONE = 2'd3
  } state_e;

  // Bytes moved for a request. A 48-bit write has no CPU meaning, so it
  // degrades to a 4-byte write.
  function automatic logic [2:0] byte_count(input logic [1:0] sz, input logic is_rd);
    logic [2:0] n;
    case (sz)
      ReqDataSz8:  n = 3'd1;
      ReqDataSz16: n = 3'd2;
      ReqDataSz32: n = 3'd4;
      default:     n = is_rd ? 3'd6 : 3'd4;
    endcase
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_mem_responder
//  Description : Serialises CPU read/write requests (1/2/4/6 bytes) onto a
//                byte-wide synchronous RAM with 1-cycle read latency, and
//                stalls the CPU through cpu_enable until the transfer is done.
//  Config      : CPU_MEM_MISALIGN_CHECK_EN - when defined, misaligned
//                requests skip the RAM and pulse err in DONE.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                req_rd/req_wr       - CPU request (both set = read)
//                req_size/addr/wdata - transfer size, byte address, data
//                cpu_enable          - 0 stalls the CPU
//                rdata               - 48-bit little-endian read result
//                err                 - misaligned-access pulse
//                mem_*               - byte RAM port
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_mem_responder
  import pkg_cpu::*;
#(
  parameter int MEM_ADDR_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_rd,
  input  logic                      req_wr,
  input  logic [1:0]                req_size,
  input  logic [31:0]               req_addr,
  input  logic [31:0]               req_wdata,
  output logic                      cpu_enable,
  output logic [47:0]               rdata,
  output logic                      err,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]                mem_wdata,
  output logic                      mem_we,
  input  logic [7:0]                mem_rdata
);

  state_e                    state_q, state_d;
  logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]               wdata_q, wdata_d;
  logic                      rd_q, rd_d;
  logic [2:0]                n_q, n_d;
  logic [2:0]                cnt_q, cnt_d;
  logic [47:0]               rdata_q, rdata_d;
  logic [2:0]                cap_idx;
  logic                      req_any;
  logic                      misaligned;

  assign req_any = req_rd | req_wr;

  // Upper CPU address bits lie outside the RAM and are intentionally ignored.
  if (MEM_ADDR_WIDTH < 32) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:MEM_ADDR_WIDTH];
  end

`ifdef CPU_MEM_MISALIGN_CHECK_EN
  logic mis_q, mis_d;

  assign misaligned = ((req_size == ReqDataSz16 || req_size == ReqDataSz48) && req_addr[0])
                    || (req_size == ReqDataSz32 && req_addr[1:0] != 2'b00);
  assign mis_d      = (state_q == IDLE && req_any) ? misaligned : mis_q;
  assign err        = !rst && (state_q == DONE) && mis_q;

  always_ff @(posedge clk) begin
    if (rst) mis_q <= 1'b0;
    else     mis_q <= mis_d;
  end
`else
  assign misaligned = 1'b0;
  assign err        = 1'b0;
`endif

  // Read data for address k arrives one cycle later: in BUSY it belongs to
  // the previous byte, in LAST to the final byte.
  assign cap_idx = (state_q == LAST) ? (n_q - 3'd1) : (cnt_q - 3'd1);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (req_any) begin
          addr_d  = req_addr[MEM_ADDR_WIDTH-1:0];
          wdata_d = req_wdata;
          rd_d    = req_rd;
          n_d     = byte_count(req_size, req_rd);
          cnt_d   = 3'd0;
          if (req_rd) rdata_d = 48'd0;
          state_d = misaligned ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (rd_q && cnt_q != 3'd0) begin
          for (int b = 0; b < 6; b++) begin
            if (cap_idx == 3'(b)) rdata_d[8*b +: 8] = mem_rdata;
          end
        end
        if (cnt_q == n_q - 3'd1) state_d = rd_q ? LAST : DONE;
        else                     cnt_d   = cnt_q + 3'd1;
      end
      LAST: begin
        for (int b = 0; b < 6; b++) begin
          if (cap_idx == 3'(b)) rdata_d[8*b +: 8] = mem_rdata;
        end
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      rd_q    <= 1'b0;
      n_q     <= 3'd0;
      cnt_q   <= 3'd0;
      rdata_q <= 48'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Outputs are gated by rst so an abort takes effect in the reset cycle
  // itself: no further byte reaches the RAM.
  assign cpu_enable = !rst && ((state_q == DONE) || (state_q == IDLE && !req_any));
  assign mem_we     = !rst && (state_q == BUSY) && !rd_q;
  assign mem_addr   = (!rst && state_q == BUSY) ? addr_q + MEM_ADDR_WIDTH'(cnt_q) : '0;
  assign mem_wdata  = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
  assign rdata      = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_mem_responder
//  Description : Directed self-checking bench for cpu_mem_responder with a
//                byte RAM model (1-cycle read latency).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_rd, req_wr;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        cpu_enable;
  logic [47:0] rdata;
  logic        err;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  cpu_mem_responder #(.MEM_ADDR_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .req_rd(req_rd), .req_wr(req_wr), .req_size(req_size),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .cpu_enable(cpu_enable), .rdata(rdata), .err(err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [0:65535];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  // Observations of the most recent transaction.
  int          lat;
  int          we_cnt;
  int          err_cnt;
  logic        en_t;
  logic        err_done;
  logic        err_after;
  logic [15:0] seq_addr [0:7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request at the current cycle t and follow it until DONE.
  task automatic run_req(input logic rd, input logic wr, input logic [1:0] sz,
                         input logic [31:0] addr, input logic [31:0] wd);
    req_rd = rd; req_wr = wr; req_size = sz; req_addr = addr; req_wdata = wd;
    #1;
    en_t = cpu_enable;
    lat = -1; we_cnt = 0; err_cnt = 0; err_done = 1'b0;
    for (int i = 0; i < 8; i++) seq_addr[i] = 16'h0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (k == 1) begin req_rd = 1'b0; req_wr = 1'b0; end
      #1;
      if (k < 8) seq_addr[k] = mem_addr;
      if (mem_we) we_cnt++;
      if (err) err_cnt++;
      if (cpu_enable) begin
        lat = k;
        err_done = err;
        break;
      end
    end
    tick();
    err_after = err;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_rd = 1'b1; req_wr = 1'b0; req_size = 2'd0;
    req_addr = 32'h0; req_wdata = 32'h0;
    tick(); tick();
    n_cmp++; if (cpu_enable !== 1'b0) begin n_bad++; $display("FAIL reset_enable got %b want 0", cpu_enable); end
    n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL reset_we got %b want 0", mem_we); end
    n_cmp++; if (mem_addr !== 16'h0) begin n_bad++; $display("FAIL reset_addr got %h want 0000", mem_addr); end
    n_cmp++; if (rdata !== 48'h0 || err !== 1'b0) begin n_bad++; $display("FAIL reset_rdata_err got %h/%b want 0/0", rdata, err); end
    rst = 1'b0; req_rd = 1'b0;
    #1;
    n_cmp++; if (cpu_enable !== 1'b1) begin n_bad++; $display("FAIL idle_enable got %b want 1", cpu_enable); end
    tick();
  endtask

  task automatic test_read_word();
    ram[16'h0010] = 8'h78; ram[16'h0011] = 8'h56; ram[16'h0012] = 8'h34; ram[16'h0013] = 8'h12;
    run_req(1'b1, 1'b0, 2'd2, 32'h0000_0010, 32'h0);
    n_cmp++; if (en_t !== 1'b0) begin n_bad++; $display("FAIL rd32_enable_t got %b want 0", en_t); end
    n_cmp++; if (lat != 6) begin n_bad++; $display("FAIL rd32_latency got %0d want 6", lat); end
    n_cmp++; if (rdata !== 48'h0000_1234_5678) begin n_bad++; $display("FAIL rd32_rdata got %h want 000012345678", rdata); end
    n_cmp++; if (we_cnt != 0) begin n_bad++; $display("FAIL rd32_we got %0d want 0", we_cnt); end
    for (int k = 1; k <= 4; k++) begin
      n_cmp++;
      if (seq_addr[k] !== 16'h0010 + 16'(k - 1)) begin
        n_bad++; $display("FAIL rd32_addr%0d got %h want %h", k, seq_addr[k], 16'h0010 + 16'(k - 1));
      end
    end
  endtask

  task automatic test_write_half();
    ram[16'h0020] = 8'h00; ram[16'h0021] = 8'h00; ram[16'h0022] = 8'h5A;
    run_req(1'b0, 1'b1, 2'd1, 32'h0000_0020, 32'hAABB_CCDD);
    n_cmp++; if (lat != 3) begin n_bad++; $display("FAIL wr16_latency got %0d want 3", lat); end
    n_cmp++; if (we_cnt != 2) begin n_bad++; $display("FAIL wr16_we_cycles got %0d want 2", we_cnt); end
    n_cmp++; if (seq_addr[1] !== 16'h0020 || seq_addr[2] !== 16'h0021) begin n_bad++; $display("FAIL wr16_addr got %h,%h want 0020,0021", seq_addr[1], seq_addr[2]); end
    n_cmp++; if (ram[16'h0020] !== 8'hDD || ram[16'h0021] !== 8'hCC) begin n_bad++; $display("FAIL wr16_data got %h,%h want DD,CC", ram[16'h0020], ram[16'h0021]); end
    n_cmp++; if (ram[16'h0022] !== 8'h5A) begin n_bad++; $display("FAIL wr16_neighbour got %h want 5A", ram[16'h0022]); end
  endtask

  task automatic test_read_wrap();
    ram[16'hFFFE] = 8'h11; ram[16'hFFFF] = 8'h22; ram[16'h0000] = 8'h33;
    ram[16'h0001] = 8'h44; ram[16'h0002] = 8'h55; ram[16'h0003] = 8'h66;
    run_req(1'b1, 1'b0, 2'd3, 32'h0000_FFFE, 32'h0);
    n_cmp++; if (lat != 8) begin n_bad++; $display("FAIL rd48_latency got %0d want 8", lat); end
    n_cmp++; if (rdata !== 48'h6655_4433_2211) begin n_bad++; $display("FAIL rd48_rdata got %h want 665544332211", rdata); end
    n_cmp++;
    if (seq_addr[1] !== 16'hFFFE || seq_addr[2] !== 16'hFFFF || seq_addr[3] !== 16'h0000 ||
        seq_addr[4] !== 16'h0001 || seq_addr[5] !== 16'h0002 || seq_addr[6] !== 16'h0003) begin
      n_bad++;
      $display("FAIL rd48_addr_seq got %h %h %h %h %h %h want fffe ffff 0000 0001 0002 0003",
               seq_addr[1], seq_addr[2], seq_addr[3], seq_addr[4], seq_addr[5], seq_addr[6]);
    end
  endtask

  task automatic test_rd_wr_both();
    ram[16'h0005] = 8'hA5;
    run_req(1'b1, 1'b1, 2'd0, 32'h0000_0005, 32'h0000_00FF);
    n_cmp++; if (we_cnt != 0) begin n_bad++; $display("FAIL both_we got %0d want 0", we_cnt); end
    n_cmp++; if (lat != 3) begin n_bad++; $display("FAIL both_latency got %0d want 3", lat); end
    n_cmp++; if (rdata !== 48'h0000_0000_00A5) begin n_bad++; $display("FAIL both_rdata got %h want 0000000000a5", rdata); end
    n_cmp++; if (ram[16'h0005] !== 8'hA5) begin n_bad++; $display("FAIL both_ram got %h want A5", ram[16'h0005]); end
  endtask

  task automatic test_write48();
    ram[16'h0044] = 8'h77;
    run_req(1'b0, 1'b1, 2'd3, 32'h0000_0040, 32'h8765_4321);
    n_cmp++; if (we_cnt != 4 || lat != 5) begin n_bad++; $display("FAIL wr48_we_lat got %0d/%0d want 4/5", we_cnt, lat); end
    n_cmp++;
    if (ram[16'h0040] !== 8'h21 || ram[16'h0041] !== 8'h43 || ram[16'h0042] !== 8'h65 ||
        ram[16'h0043] !== 8'h87 || ram[16'h0044] !== 8'h77) begin
      n_bad++;
      $display("FAIL wr48_data got %h %h %h %h %h want 21 43 65 87 77", ram[16'h0040],
               ram[16'h0041], ram[16'h0042], ram[16'h0043], ram[16'h0044]);
    end
  endtask

  task automatic test_misalign();
`ifdef CPU_MEM_MISALIGN_CHECK_EN
    run_req(1'b1, 1'b0, 2'd2, 32'h0000_0002, 32'h0);
    n_cmp++; if (lat != 1) begin n_bad++; $display("FAIL mis_latency got %0d want 1", lat); end
    n_cmp++; if (err_done !== 1'b1 || err_cnt != 1) begin n_bad++; $display("FAIL mis_err got %b/%0d want 1/1", err_done, err_cnt); end
    n_cmp++; if (err_after !== 1'b0) begin n_bad++; $display("FAIL mis_err_clear got %b want 0", err_after); end
    n_cmp++; if (rdata !== 48'h0 || we_cnt != 0 || seq_addr[1] !== 16'h0) begin n_bad++; $display("FAIL mis_noaccess got %h/%0d/%h want 0/0/0", rdata, we_cnt, seq_addr[1]); end
`else
    run_req(1'b1, 1'b0, 2'd1, 32'h0000_0021, 32'h0);
    n_cmp++; if (lat != 4) begin n_bad++; $display("FAIL mis_latency got %0d want 4", lat); end
    n_cmp++; if (rdata !== 48'h0000_0000_5ACC) begin n_bad++; $display("FAIL mis_rdata got %h want 000000005acc", rdata); end
    n_cmp++; if (err_cnt != 0) begin n_bad++; $display("FAIL mis_err got %0d want 0", err_cnt); end
`endif
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) ram[16'h0030 + 16'(i)] = 8'h00;
    req_rd = 1'b0; req_wr = 1'b1; req_size = 2'd2; req_addr = 32'h0000_0030; req_wdata = 32'h4433_2211;
    tick();
    req_wr = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    n_cmp++; if (cpu_enable !== 1'b0 || mem_we !== 1'b0) begin n_bad++; $display("FAIL rstmid_during got %b/%b want 0/0", cpu_enable, mem_we); end
    tick();
    rst = 1'b0;
    #1;
    n_cmp++; if (cpu_enable !== 1'b1 || mem_we !== 1'b0) begin n_bad++; $display("FAIL rstmid_idle got %b/%b want 1/0", cpu_enable, mem_we); end
    n_cmp++; if (rdata !== 48'h0) begin n_bad++; $display("FAIL rstmid_rdata got %h want 0", rdata); end
    tick(); tick(); tick();
    n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL rstmid_no_resume got %b want 0", mem_we); end
    n_cmp++;
    if (ram[16'h0030] !== 8'h11 || ram[16'h0031] !== 8'h22 || ram[16'h0032] !== 8'h00 || ram[16'h0033] !== 8'h00) begin
      n_bad++;
      $display("FAIL rstmid_ram got %h %h %h %h want 11 22 00 00", ram[16'h0030], ram[16'h0031], ram[16'h0032], ram[16'h0033]);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    mem_rdata = 8'h00;
    test_reset();
    test_read_word();
    test_write_half();
    test_read_wrap();
    test_rd_wr_both();
    test_write48();
    test_misalign();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
